// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage: XLEN, reset/NOP constants, fetch FSM encoding.
// FETCH_FAULT is only reachable when IF_MISALIGN_CHK_EN is defined.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// fetch_fault_o is present only when IF_MISALIGN_CHK_EN is defined.
interface instr_fetch_if;
    import riscv_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    // Decode handshake: a word transfers on a cycle where instr_valid_o && instr_ready_i;
    // once raised, instr_valid_o/instr_o/pc_o stay stable until that transfer or a redirect.
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    fetch_state_e    state_dbg_o;
`ifdef IF_MISALIGN_CHK_EN
    logic            fetch_fault_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               state_dbg_o, fetch_fault_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               state_dbg_o, fetch_fault_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
`else
    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               state_dbg_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               state_dbg_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
`endif

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirect targets in a FAULT state.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            kill_q, kill_d;
    logic            redir_misaligned;

`ifdef IF_MISALIGN_CHK_EN
    assign redir_misaligned = bus.redirect_pc_i[1:0] != 2'b00;
`else
    assign redir_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        kill_d  = kill_q;
        if (bus.redirect_i) begin
            kill_d = 1'b0;
            if (redir_misaligned) begin
                pc_d    = bus.redirect_pc_i;
                state_d = ST_FAULT;
            end else begin
                pc_d    = word_align(bus.redirect_pc_i);
                state_d = ST_REQ;
                // A request already accepted by memory must still drain its rvalid.
                if (state_q == ST_REQ && bus.imem_gnt_i) begin
                    state_d = ST_WAIT;
                    kill_d  = 1'b1;
                end else if (state_q == ST_WAIT && !bus.imem_rvalid_i) begin
                    state_d = ST_WAIT;
                    kill_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (bus.imem_gnt_i) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            instr_d = bus.imem_rdata_i;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready_i) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.imem_req_o    = state_q == ST_REQ;
        bus.imem_addr_o   = pc_q;
        bus.instr_valid_o = state_q == ST_HOLD;
        bus.instr_o       = (state_q == ST_HOLD) ? instr_q : NOP_INSTR;
        bus.pc_o          = pc_q;
        bus.pc_plus4_o    = pc_q + 32'd4;
        bus.state_dbg_o   = state_q;
`ifdef IF_MISALIGN_CHK_EN
        bus.fetch_fault_o = state_q == ST_FAULT;
`endif
    end

endmodule
